flag_sequencer: RTL and testbench
=================================

Name: flag_sequencer

Overview:
- Frame-synchronous flag selector for the VGA pride display. It holds the current flag index that drives the combinational flag mux.
- Advances the index from debounced next/prev buttons, a direct load, or an auto-cycle dwell timer.
- Index changes only at frame boundaries, optionally hidden behind a blanking interval of whole frames, so no frame shows two flags.
- Sits between the input pins / VGA timing generator and the flag mux selector input.

Parameters:
- NUM_FLAGS, 82, number of selectable flags; valid indices are 0..NUM_FLAGS-1
- SEL_W, 7, width of selector/max/load_value; must satisfy 2^SEL_W >= NUM_FLAGS
- DWELL_FRAMES, 120, frames a flag is shown before auto-advance; minimum 1
- BLANK_FRAMES, 2, frames of blanking around each change; 0 disables blanking
- RESET_FLAG, 0, selector value after reset; must be < NUM_FLAGS

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame from the VGA timing generator (synchronous to clk)
- btn_next  in  1  asynchronous button, advance index
- btn_prev  in  1  asynchronous button, retreat index
- auto_en  in  1  synchronous level, enables auto-cycling
- load_strobe  in  1  synchronous one-cycle pulse, request jump to load_value
- load_value  in  SEL_W  target index for load_strobe
- selector  out  SEL_W  registered current flag index
- max  out  SEL_W  constant NUM_FLAGS-1
- blank  out  1  registered; 1 forces the pixel output to black
- changed  out  1  one-cycle pulse in the cycle after selector updates

Behaviour:
- Reset (async assert, sync release) forces:
  - selector=RESET_FLAG, blank=0, changed=0
  - state SHOW, dwell and blank counters 0
  - pending request NONE
  - sync flops 0
- Button path:
  - btn_next and btn_prev each pass through 2-flop synchronizers, then a registered rising-edge detector.
  - An edge registers a pending request at the 3rd clk edge after the input rises.
  - Holding a button produces exactly one request.
- Pending request register (one entry; NONE/NEXT/PREV/LOAD plus a captured load target):
  - Priority when new events occur in the same cycle: load_strobe > button > auto.
  - Next and prev edges in the same cycle cancel; pending is unchanged.
  - A new request overwrites an older pending one, except that no event overwrites LOAD.
  - The load target is clamped: load_value >= NUM_FLAGS captures NUM_FLAGS-1.
- Target computation:
  - NEXT: NUM_FLAGS-1 wraps to 0.
  - PREV: 0 wraps to NUM_FLAGS-1.
  - LOAD: the captured, clamped value.
- Auto-cycle:
  - In SHOW with auto_en=1, each frame_tick increments the dwell counter.
  - When a tick arrives with the counter at DWELL_FRAMES-1, a NEXT is posted as pending (lowest priority) and the counter clears.
  - auto_en=0 holds the counter at 0.
  - The counter also clears whenever selector changes.
- State machine:
  - SHOW, frame_tick=1, pending!=NONE, BLANK_FRAMES=0: selector<=target at that edge, pending<=NONE, stay in SHOW.
  - SHOW, frame_tick=1, pending!=NONE, BLANK_FRAMES>0: go to BLANK, blank<=1, latch target, pending<=NONE, blank counter<=0.
  - BLANK: each frame_tick increments the blank counter. On the tick where the counter equals BLANK_FRAMES-1: selector<=latched target, blank<=0, return to SHOW.
  - Requests arriving during BLANK stay pending. They are served at the first frame_tick in SHOW, never at the exit tick.
  - A target equal to the current selector still runs the full sequence (blank, changed pulse).
- changed:
  - Asserts for exactly one cycle, the cycle after any selector update.
  - No pulse on reset.
- All outputs are registered and glitch-free; max is a constant.
- A reset asserted mid-BLANK returns to the reset state immediately; the latched target is discarded.

Test Plan:
- Reset with RESET_FLAG=0, no stimulus -> selector=0, blank=0, changed=0, max=81 (NUM_FLAGS=82).
- BLANK_FRAMES=0, selector=81, pulse btn_next, then frame_tick -> selector=0 at the tick edge, changed high one cycle; btn_prev then tick -> selector=81.
- BLANK_FRAMES=2, selector=5, btn_next, three frame_ticks -> blank=1 after tick 1, still selector=5 after tick 2, selector=6 and blank=0 after tick 3; changed after tick 3 only.
- btn_next and btn_prev rise in the same cycle, then 3 ticks -> selector unchanged, no changed pulse; btn_next held high 10 frames -> exactly one advance.
- load_strobe with load_value=100 in the same cycle as a btn_next edge, BLANK_FRAMES=0 -> selector=81 at the next tick; load_value=40 -> selector=40.
- DWELL_FRAMES=3, auto_en=1, BLANK_FRAMES=0, selector=0 -> selector=1 at tick 3 and 2 at tick 6; assert rst_n=0 mid-sequence -> selector=0 asynchronously and the dwell count restarts.

Source files
------------

// File: rtl/flag_sequencer.sv
// Frame-synchronous flag selector for the VGA pride display.
// Holds the current flag index and changes it only on frame boundaries.
// Changes come from debounced next/prev buttons, a direct load, or an
// auto-cycle dwell timer. An optional blanking interval of whole frames
// hides each change.
module flag_sequencer #(
    parameter int NUM_FLAGS    = 82,
    parameter int SEL_W        = 7,
    parameter int DWELL_FRAMES = 120,
    parameter int BLANK_FRAMES = 2,
    parameter int RESET_FLAG   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             auto_en,
    input  logic             load_strobe,
    input  logic [SEL_W-1:0] load_value,
    output logic [SEL_W-1:0] selector,
    output logic [SEL_W-1:0] max,
    output logic             blank,
    output logic             changed
);

    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

    localparam logic [SEL_W-1:0] MAX_IDX     = SEL_W'(NUM_FLAGS - 1);
    localparam logic [SEL_W-1:0] RESET_IDX   = SEL_W'(RESET_FLAG);
    localparam logic [DW-1:0]    DWELL_LAST  = DW'(DWELL_FRAMES - 1);
    localparam logic [BW-1:0]    BLANK_LAST  = BW'((BLANK_FRAMES > 0) ? (BLANK_FRAMES - 1) : 0);

    typedef enum logic {
        ST_SHOW,
        ST_BLANK
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_NEXT,
        REQ_PREV,
        REQ_LOAD
    } req_t;

    state_t           state;
    req_t             pend_kind;
    logic [SEL_W-1:0] pend_load;
    logic [SEL_W-1:0] latched;
    logic [BW-1:0]    blank_cnt;
    logic [DW-1:0]    dwell_cnt;

    logic [1:0]       next_sync;
    logic [1:0]       prev_sync;
    logic             next_q;
    logic             prev_q;
    logic             next_edge;
    logic             prev_edge;

    req_t             new_kind;
    logic [SEL_W-1:0] new_load;
    req_t             merged_kind;
    logic [SEL_W-1:0] merged_load;
    logic [SEL_W-1:0] target;
    logic             auto_fire;
    logic             serve;
    logic             sel_update;

    assign max = MAX_IDX;

    // Two-flop synchronizers plus edge-history flops for both buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_sync <= '0;
            prev_sync <= '0;
            next_q    <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            next_sync <= {next_sync[0], btn_next};
            prev_sync <= {prev_sync[0], btn_prev};
            next_q    <= next_sync[1];
            prev_q    <= prev_sync[1];
        end
    end

    assign next_edge = next_sync[1] & ~next_q;
    assign prev_edge = prev_sync[1] & ~prev_q;

    assign auto_fire = auto_en && (state == ST_SHOW) && frame_tick && (dwell_cnt == DWELL_LAST);

    // Merge this cycle's events into the pending request. The auto event is
    // folded in here so a dwell expiry is served on the very tick it fires.
    always_comb begin
        new_kind    = REQ_NONE;
        new_load    = pend_load;
        merged_kind = pend_kind;
        merged_load = pend_load;
        if (load_strobe) begin
            new_kind = REQ_LOAD;
            new_load = (load_value > MAX_IDX) ? MAX_IDX : load_value;
        end else if (next_edge && !prev_edge) begin
            new_kind = REQ_NEXT;
        end else if (prev_edge && !next_edge) begin
            new_kind = REQ_PREV;
        end else if (auto_fire) begin
            new_kind = REQ_NEXT;
        end
        if ((new_kind != REQ_NONE) && (pend_kind != REQ_LOAD)) begin
            merged_kind = new_kind;
            merged_load = new_load;
        end
    end

    // Destination index for the merged request, with wrap at both ends
    always_comb begin
        target = selector;
        case (merged_kind)
            REQ_NEXT: target = (selector == MAX_IDX) ? '0 : selector + 1'b1;
            REQ_PREV: target = (selector == '0) ? MAX_IDX : selector - 1'b1;
            REQ_LOAD: target = merged_load;
            default:  target = selector;
        endcase
    end

    assign serve      = (state == ST_SHOW) && frame_tick && (merged_kind != REQ_NONE);
    assign sel_update = (serve && (BLANK_FRAMES == 0)) ||
                        ((state == ST_BLANK) && frame_tick && (blank_cnt == BLANK_LAST));

    // Sequencer FSM: serves requests at frame ticks, optionally via blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SHOW;
            selector  <= RESET_IDX;
            blank     <= 1'b0;
            changed   <= 1'b0;
            pend_kind <= REQ_NONE;
            pend_load <= '0;
            latched   <= '0;
            blank_cnt <= '0;
        end else begin
            changed   <= sel_update;
            pend_kind <= merged_kind;
            pend_load <= merged_load;
            case (state)
                ST_SHOW: begin
                    if (serve) begin
                        pend_kind <= REQ_NONE;
                        if (BLANK_FRAMES == 0) begin
                            selector <= target;
                        end else begin
                            state     <= ST_BLANK;
                            blank     <= 1'b1;
                            latched   <= target;
                            blank_cnt <= '0;
                        end
                    end
                end
                ST_BLANK: begin
                    if (frame_tick) begin
                        if (blank_cnt == BLANK_LAST) begin
                            selector <= latched;
                            blank    <= 1'b0;
                            state    <= ST_SHOW;
                        end else begin
                            blank_cnt <= blank_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_SHOW;
            endcase
        end
    end

    // Dwell timer: counts shown frames, restarts on any selector update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (!auto_en || sel_update) begin
            dwell_cnt <= '0;
        end else if ((state == ST_SHOW) && frame_tick) begin
            dwell_cnt <= auto_fire ? '0 : dwell_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_flag_sequencer.sv
// Bench for flag_sequencer: two instances (no blanking with a short dwell,
// and two-frame blanking with the default dwell) share one directed stimulus
// stream. A frame-level model checks every cycle; literal checks pin it.
module tb_flag_sequencer;

    localparam int NF   = 82;
    localparam int NB_A = 0;
    localparam int ND_A = 3;
    localparam int NB_B = 2;
    localparam int ND_B = 120;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic       load_strobe;
    logic [6:0] load_value;

    logic [6:0] sel_a, max_a, sel_b, max_b;
    logic       blank_a, changed_a, blank_b, changed_b;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    flag_sequencer #(
        .NUM_FLAGS(NF), .SEL_W(7), .DWELL_FRAMES(ND_A), .BLANK_FRAMES(NB_A), .RESET_FLAG(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_next(btn_next),
        .btn_prev(btn_prev), .auto_en(auto_en), .load_strobe(load_strobe),
        .load_value(load_value), .selector(sel_a), .max(max_a), .blank(blank_a),
        .changed(changed_a)
    );

    flag_sequencer #(
        .NUM_FLAGS(NF), .SEL_W(7), .DWELL_FRAMES(ND_B), .BLANK_FRAMES(NB_B), .RESET_FLAG(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_next(btn_next),
        .btn_prev(btn_prev), .auto_en(auto_en), .load_strobe(load_strobe),
        .load_value(load_value), .selector(sel_b), .max(max_b), .blank(blank_b),
        .changed(changed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- frame-level model ----------------
    // pkind: 0 none, 1 next, 2 prev, 3 load
    typedef struct {
        int sel;
        bit blnk;
        bit chg;
        int pkind;
        int ptgt;
        int shown_ticks;
        bit in_blank;
        int frames_left;
        int dest;
    } mstate_t;

    mstate_t m_a, m_b;
    logic [2:0] hist_n, hist_p;

    function automatic mstate_t reset_state();
        mstate_t r;
        r.sel = 0; r.blnk = 0; r.chg = 0; r.pkind = 0; r.ptgt = 0;
        r.shown_ticks = 0; r.in_blank = 0; r.frames_left = 0; r.dest = 0;
        return r;
    endfunction

    function automatic mstate_t step(mstate_t m, bit tick, bit nev, bit pev, bit aen,
                                     bit ld, int lv, int nb, int nd);
        mstate_t r = m;
        int req = m.pkind;
        int tgt = m.ptgt;
        int newreq = 0;
        int newtgt = 0;
        int dst;
        bit upd = 0;
        bit af;
        af = aen && !m.in_blank && tick && (m.shown_ticks == nd - 1);
        if (ld) begin
            newreq = 3;
            newtgt = (lv > NF - 1) ? NF - 1 : lv;
        end else if (nev != pev) begin
            newreq = nev ? 1 : 2;
        end else if (af) begin
            newreq = 1;
        end
        if (newreq != 0 && req != 3) begin
            req = newreq;
            tgt = newtgt;
        end
        if (!m.in_blank) begin
            if (tick && req != 0) begin
                dst = (req == 1) ? (m.sel + 1) % NF :
                      (req == 2) ? (m.sel + NF - 1) % NF : tgt;
                req = 0;
                if (nb == 0) begin
                    r.sel = dst;
                    upd = 1;
                end else begin
                    r.in_blank = 1;
                    r.blnk = 1;
                    r.dest = dst;
                    r.frames_left = nb;
                end
            end
        end else if (tick) begin
            r.frames_left = m.frames_left - 1;
            if (r.frames_left == 0) begin
                r.sel = m.dest;
                r.blnk = 0;
                r.in_blank = 0;
                upd = 1;
            end
        end
        r.pkind = req;
        r.ptgt = tgt;
        r.chg = upd;
        if (!aen || upd) r.shown_ticks = 0;
        else if (!m.in_blank && tick) r.shown_ticks = af ? 0 : m.shown_ticks + 1;
        return r;
    endfunction

    // Model advances on every clock edge and resets with the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a    <= reset_state();
            m_b    <= reset_state();
            hist_n <= '0;
            hist_p <= '0;
        end else begin
            m_a <= step(m_a, frame_tick, hist_n[1] & ~hist_n[2], hist_p[1] & ~hist_p[2],
                        auto_en, load_strobe, int'(load_value), NB_A, ND_A);
            m_b <= step(m_b, frame_tick, hist_n[1] & ~hist_n[2], hist_p[1] & ~hist_p[2],
                        auto_en, load_strobe, int'(load_value), NB_B, ND_B);
            hist_n <= {hist_n[1:0], btn_next};
            hist_p <= {hist_p[1:0], btn_prev};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_sel", 32'(sel_a), 32'(m_a.sel));
            chk("a_blank", 32'(blank_a), 32'(m_a.blnk));
            chk("a_changed", 32'(changed_a), 32'(m_a.chg));
            chk("a_max", 32'(max_a), 32'(NF - 1));
            chk("b_sel", 32'(sel_b), 32'(m_b.sel));
            chk("b_blank", 32'(blank_b), 32'(m_b.blnk));
            chk("b_changed", 32'(changed_b), 32'(m_b.chg));
            chk("b_max", 32'(max_b), 32'(NF - 1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick_start();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic tick();
        tick_start();
        settle();
    endtask

    task automatic press(input bit n, input bit p);
        @(negedge clk);
        btn_next = n;
        btn_prev = p;
        repeat (5) @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic load(input logic [6:0] v);
        @(negedge clk);
        load_strobe = 1'b1;
        load_value  = v;
        @(negedge clk);
        load_strobe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        frame_tick = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
        auto_en = 1'b0; load_strobe = 1'b0; load_value = '0;
        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_a_sel", 32'(sel_a), 32'd0);
        chk("rst_b_sel", 32'(sel_b), 32'd0);
        chk("rst_a_blank", 32'(blank_a), 32'd0);
        chk("rst_b_blank", 32'(blank_b), 32'd0);
        chk("rst_a_changed", 32'(changed_a), 32'd0);
        chk("rst_max", 32'(max_a), 32'd81);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_a_sel", 32'(sel_a), 32'd0);

        // Wrap tests without blanking (instance A); B follows three frames later
        load(7'd81);
        repeat (3) tick();
        chk("load81_a", 32'(sel_a), 32'd81);
        chk("load81_b", 32'(sel_b), 32'd81);
        press(1'b1, 1'b0);
        tick_start();
        chk("wrap_next_a", 32'(sel_a), 32'd0);
        chk("wrap_next_a_chg", 32'(changed_a), 32'd1);
        @(negedge clk);
        chk("wrap_next_a_chg_end", 32'(changed_a), 32'd0);
        settle();
        tick(); tick();
        chk("wrap_next_b", 32'(sel_b), 32'd0);
        press(1'b0, 1'b1);
        tick();
        chk("wrap_prev_a", 32'(sel_a), 32'd81);
        tick(); tick();
        chk("wrap_prev_b", 32'(sel_b), 32'd81);

        // Blanking sequence on instance B
        load(7'd5);
        repeat (3) tick();
        chk("load5_b", 32'(sel_b), 32'd5);
        press(1'b1, 1'b0);
        tick();
        chk("blank_t1_b_blank", 32'(blank_b), 32'd1);
        chk("blank_t1_b_sel", 32'(sel_b), 32'd5);
        chk("blank_t1_a_sel", 32'(sel_a), 32'd6);
        tick();
        chk("blank_t2_b_blank", 32'(blank_b), 32'd1);
        chk("blank_t2_b_sel", 32'(sel_b), 32'd5);
        tick_start();
        chk("blank_t3_b_sel", 32'(sel_b), 32'd6);
        chk("blank_t3_b_blank", 32'(blank_b), 32'd0);
        chk("blank_t3_b_chg", 32'(changed_b), 32'd1);
        settle();

        // Simultaneous next/prev cancel, then a held button advances once
        press(1'b1, 1'b1);
        repeat (3) tick();
        chk("cancel_a", 32'(sel_a), 32'd6);
        chk("cancel_b", 32'(sel_b), 32'd6);
        @(negedge clk) btn_next = 1'b1;
        repeat (10) tick();
        btn_next = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_a", 32'(sel_a), 32'd7);
        chk("held_b", 32'(sel_b), 32'd7);

        // Load with an out-of-range value alongside a button edge
        @(negedge clk) btn_next = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load_strobe = 1'b1;
        load_value  = 7'd100;
        @(negedge clk) load_strobe = 1'b0;
        repeat (3) tick();
        btn_next = 1'b0;
        repeat (4) @(negedge clk);
        chk("clamp_a", 32'(sel_a), 32'd81);
        chk("clamp_b", 32'(sel_b), 32'd81);
        load(7'd40);
        repeat (3) tick();
        chk("load40_a", 32'(sel_a), 32'd40);
        chk("load40_b", 32'(sel_b), 32'd40);

        // Auto-cycle on A, then reset mid-blank on B
        load(7'd0);
        repeat (3) tick();
        @(negedge clk) auto_en = 1'b1;
        tick(); tick();
        chk("auto_t2_a", 32'(sel_a), 32'd0);
        tick();
        chk("auto_t3_a", 32'(sel_a), 32'd1);
        tick(); tick(); tick();
        chk("auto_t6_a", 32'(sel_a), 32'd2);
        chk("auto_t6_b", 32'(sel_b), 32'd0);
        load(7'd50);
        tick();
        chk("pre_rst_a", 32'(sel_a), 32'd50);
        chk("pre_rst_b_blank", 32'(blank_b), 32'd1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_a_sel", 32'(sel_a), 32'd0);
        chk("async_rst_b_sel", 32'(sel_b), 32'd0);
        chk("async_rst_b_blank", 32'(blank_b), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        chk("restart_t2_a", 32'(sel_a), 32'd0);
        tick();
        chk("restart_t3_a", 32'(sel_a), 32'd1);
        chk("restart_t3_b", 32'(sel_b), 32'd0);
        chk("restart_t3_b_blank", 32'(blank_b), 32'd0);

        repeat (2) @(negedge clk);
        finish_run();
    end

endmodule
